// File: rtl/contour_mesh_engine_if.sv
// Pixel-in and contour-out valid/ready streams
// for the contour mesh engine.
interface contour_mesh_engine_if #(
   parameter int PW = 2
);
   logic          pix_valid;
   logic [PW-1:0] pix_data;
   logic          pix_ready;
   logic          out_valid;
   logic          out_bit;
   logic          out_ready;

   modport master (
      output pix_valid, pix_data, out_ready,
      input  pix_ready, out_valid, out_bit
   );

   modport slave (
      input  pix_valid, pix_data, out_ready,
      output pix_ready, out_valid, out_bit
   );
endinterface

// File: rtl/contour_mesh_engine.sv
// Loads a W x H toroidal pixel mesh, flags interior
// cells, then streams one contour bit per cell.
module contour_mesh_engine #(
   parameter int W  = 26,
   parameter int H  = 18,
   parameter int PW = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             algo,
   contour_mesh_engine_if.slave   io,
   output logic                   busy,
   output logic                   done
);
   localparam int N  = W * H;
   localparam int IW = $clog2(N);
   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_CLASS, S_EMIT
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             algo_q, algo_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [RW-1:0]          row_q, row_d;
   logic [CW-1:0]          col_q, col_d;
   logic                   done_q, done_d;
   logic [N-1:0]           flag_q, flag_d;
   logic [N-1:0][PW-1:0]   buf_q, buf_d;

   logic [IW-1:0] nb_n, nb_s, nb_e, nb_w;
   logic          eq_n, eq_s, eq_e, eq_w;
   logic          interior, vertex, bit_sel;
   logic          last, adv, clr;

   // Toroidal neighbour indices of the current cell.
   always_comb begin
      nb_n = (row_q == '0) ? idx_q + IW'(N - W)
                           : idx_q - IW'(W);
      nb_s = (row_q == RW'(H - 1)) ? idx_q - IW'(N - W)
                                   : idx_q + IW'(W);
      nb_e = (col_q == CW'(W - 1)) ? idx_q - IW'(W - 1)
                                   : idx_q + IW'(1);
      nb_w = (col_q == '0) ? idx_q + IW'(W - 1)
                           : idx_q - IW'(1);
   end

   // Neighbour equality and the per-mode contour bit.
   always_comb begin
      eq_n     = buf_q[idx_q] == buf_q[nb_n];
      eq_s     = buf_q[idx_q] == buf_q[nb_s];
      eq_e     = buf_q[idx_q] == buf_q[nb_e];
      eq_w     = buf_q[idx_q] == buf_q[nb_w];
      interior = eq_n & eq_s & eq_e & eq_w;
      vertex   = (flag_q[idx_q] != flag_q[nb_e])
               | (flag_q[idx_q] != flag_q[nb_s]);
      bit_sel  = 1'b0;
      case (algo_q)
         2'b00:   bit_sel = ~flag_q[idx_q];
         2'b01:   bit_sel = eq_e ^ eq_s;
         2'b10:   bit_sel = vertex;
         default: bit_sel = 1'b0;
      endcase
   end

   // Next-state, buffer/flag writes and raster counters.
   always_comb begin
      state_d = state_q;
      algo_d  = algo_q;
      idx_d   = idx_q;
      row_d   = row_q;
      col_d   = col_q;
      done_d  = 1'b0;
      flag_d  = flag_q;
      buf_d   = buf_q;
      adv     = 1'b0;
      clr     = 1'b0;
      last    = idx_q == IW'(N - 1);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               algo_d  = algo;
               clr     = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (io.pix_valid) begin
               buf_d[idx_q] = io.pix_data;
               adv          = 1'b1;
               if (last) state_d = S_CLASS;
            end
         end
         S_CLASS: begin
            flag_d[idx_q] = interior;
            adv           = 1'b1;
            if (last) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (io.out_ready) begin
               adv = 1'b1;
               if (last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
      if (clr || (adv && last)) begin
         idx_d = '0;
         row_d = '0;
         col_d = '0;
      end else if (adv) begin
         idx_d = idx_q + IW'(1);
         if (col_q == CW'(W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Control state; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         algo_q  <= '0;
         idx_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         done_q  <= 1'b0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         algo_q  <= algo_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         col_q   <= col_d;
         done_q  <= done_d;
         flag_q  <= flag_d;
      end
   end

   // Pixel buffer holds its contents across reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign io.pix_ready = state_q == S_LOAD;
   assign io.out_valid = state_q == S_EMIT;
   assign io.out_bit   = (state_q == S_EMIT) & bit_sel;
   assign busy         = state_q != S_IDLE;
   assign done         = done_q;
endmodule

// File: tb/tb_contour_mesh_engine.sv
// Directed bench for contour_mesh_engine on a
// 4x4 mesh with hand-computed contour masks.
module tb_contour_mesh_engine;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 2;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    algo;
   logic          busy;
   logic          done;
   logic [PW-1:0] pix [N];
   logic [15:0]   bits;
   int            cyc;
   int            n_run  = 0;
   int            n_fail = 0;

   contour_mesh_engine_if #(.PW(PW)) io ();

   contour_mesh_engine #(
      .W(W), .H(H), .PW(PW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .algo  (algo),
      .io    (io.slave),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic fill(input logic [1:0] bg,
                       input int k1,
                       input logic [1:0] v1);
      for (int i = 0; i < N; i++) pix[i] = bg;
      if (k1 >= 0) pix[k1] = v1;
   endtask

   task automatic frame(input logic [1:0] a,
                        input bit stall,
                        input bit spoke,
                        output logic [15:0] ob_mask,
                        output int lat);
      int   n, k;
      logic hp, ho, ob, hold, hb;
      start = 1'b1;
      algo  = a;
      @(posedge clk);
      #1;
      start   = 1'b0;
      algo    = ~a;
      lat     = 1;
      n       = 0;
      k       = 0;
      ob_mask = '0;
      while (!done && lat < 300) begin
         io.pix_valid = 1'b1;
         io.pix_data  = pix[n % N];
         io.out_ready = stall ? ((lat % 4) == 0 || (lat % 4) == 3)
                              : 1'b1;
         start = spoke && io.out_valid;
         hp    = io.pix_valid && io.pix_ready;
         ho    = io.out_valid && io.out_ready;
         ob    = io.out_bit;
         hold  = io.out_valid && !io.out_ready;
         hb    = io.out_bit;
         @(posedge clk);
         #1;
         lat++;
         if (hp) n++;
         if (ho) begin
            if (k < N) ob_mask[k] = ob;
            k++;
         end
         if (hold && io.out_valid)
            chk("hold_bit", {31'b0, io.out_bit}, {31'b0, hb});
      end
      start = 1'b0;
      chk("done_seen", {31'b0, done}, 32'd1);
      chk("pix_count", n, N);
      chk("bit_count", k, N);
      chk("idle_at_done", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'b0, done}, 32'd0);
      chk("still_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      algo         = 2'b00;
      io.pix_valid = 1'b0;
      io.pix_data  = '0;
      io.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_ready", {31'b0, io.pix_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
      chk("rst_out_bit", {31'b0, io.out_bit}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      fill(2'b01, -1, 2'b00);
      frame(2'b00, 1'b0, 1'b0, bits, cyc);
      chk("flat_bits", {16'b0, bits}, 32'h0000);
      chk("flat_latency", cyc, 49);

      fill(2'b01, 5, 2'b11);
      frame(2'b00, 1'b0, 1'b0, bits, cyc);
      chk("px5_pixel_bits", {16'b0, bits}, 32'h0272);
      chk("px5_latency", cyc, 49);

      fill(2'b00, 0, 2'b10);
      frame(2'b00, 1'b0, 1'b0, bits, cyc);
      chk("wrap_bits", {16'b0, bits}, 32'h101B);

      fill(2'b01, 5, 2'b11);
      frame(2'b01, 1'b0, 1'b0, bits, cyc);
      chk("rdbf_bits", {16'b0, bits}, 32'h0012);

      frame(2'b10, 1'b0, 1'b0, bits, cyc);
      chk("vertex_bits", {16'b0, bits}, 32'h23D7);

      frame(2'b00, 1'b1, 1'b0, bits, cyc);
      chk("stall_bits", {16'b0, bits}, 32'h0272);

      frame(2'b11, 1'b0, 1'b1, bits, cyc);
      chk("rsvd_bits", {16'b0, bits}, 32'h0000);
      chk("rsvd_latency", cyc, 49);

      start = 1'b1;
      algo  = 2'b00;
      @(posedge clk);
      #1;
      start        = 1'b0;
      io.pix_valid = 1'b1;
      io.pix_data  = 2'b11;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_load_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_pix_ready", {31'b0, io.pix_ready}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      rst          = 1'b0;
      io.pix_valid = 1'b0;
      @(posedge clk);
      #1;

      fill(2'b00, 0, 2'b10);
      frame(2'b00, 1'b0, 1'b0, bits, cyc);
      chk("reload_bits", {16'b0, bits}, 32'h101B);
      chk("reload_latency", cyc, 49);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
